// File: rtl/fft_sequencer.sv
// Control sequencer for the 64-point in-place radix-2 FFT: load, six butterfly levels with
// per-level pipeline drain, then result streaming. Also delays the read strobe to a write-back strobe.
module fft_sequencer #(
  parameter int unsigned BFLY_LAT = 2
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       start,
  input  logic       sample_valid,
  output logic       sample_ready,
  output logic       load,
  output logic       processing,
  output logic       done,
  output logic [5:0] fft_level,
  output logic [5:0] butterfly_iter,
  output logic [5:0] load_address,
  output logic [5:0] out_address,
  output logic       load_we,
  output logic       rd_en,
  output logic       wr_en,
  output logic [5:0] wr_iter,
  output logic [5:0] wr_level,
  output logic       rd_bank,
  output logic       out_valid,
  input  logic       out_ready,
  output logic       busy
);

  localparam int unsigned AW       = 6;
  localparam int unsigned LVW      = 3;
  localparam int unsigned ITW      = 5;
  localparam int unsigned DRW      = 3;
  localparam int unsigned LAST_LVL = 5;
  localparam int unsigned LAST_WB  = BFLY_LAT - 1;

  typedef enum logic [2:0] {S_IDLE, S_LOAD, S_PROC, S_DRAIN, S_OUT} state_t;

  typedef struct packed {
    logic          en;
    logic [AW-1:0] iter;
    logic [AW-1:0] level;
  } wb_t;

  state_t         state_q, state_d;
  logic [AW-1:0]  cnt_q, cnt_d;
  logic [LVW-1:0] level_q, level_d;
  logic [ITW-1:0] iter_q, iter_d;
  logic [DRW-1:0] drain_q, drain_d;
  wb_t            wb_q [BFLY_LAT];

  // Next-state and counter update.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    level_d = level_q;
    iter_d  = iter_q;
    drain_d = drain_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_LOAD;
          cnt_d   = '0;
        end
      end
      S_LOAD: begin
        if (sample_valid) begin
          if (cnt_q == AW'(63)) begin
            state_d = S_PROC;
            level_d = '0;
            iter_d  = '0;
          end else begin
            cnt_d = cnt_q + AW'(1);
          end
        end
      end
      S_PROC: begin
        if (iter_q == ITW'(31)) begin
          state_d = S_DRAIN;
          drain_d = '0;
        end else begin
          iter_d = iter_q + ITW'(1);
        end
      end
      S_DRAIN: begin
        if (drain_q == DRW'(LAST_WB)) begin
          if (level_q < LVW'(LAST_LVL)) begin
            state_d = S_PROC;
            level_d = level_q + LVW'(1);
            iter_d  = '0;
          end else begin
            state_d = S_OUT;
            cnt_d   = '0;
          end
        end else begin
          drain_d = drain_q + DRW'(1);
        end
      end
      S_OUT: begin
        if (out_ready) begin
          if (cnt_q == AW'(63)) state_d = S_IDLE;
          else                  cnt_d   = cnt_q + AW'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Outputs are decoded from next-state values so the registers track the state they describe.
  logic in_load_d, in_proc_d, in_bfly_d, in_out_d;
  assign in_load_d = (state_d == S_LOAD);
  assign in_proc_d = (state_d == S_PROC);
  assign in_bfly_d = (state_d == S_PROC) || (state_d == S_DRAIN);
  assign in_out_d  = (state_d == S_OUT);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q        <= S_IDLE;
      cnt_q          <= '0;
      level_q        <= '0;
      iter_q         <= '0;
      drain_q        <= '0;
      sample_ready   <= 1'b0;
      load           <= 1'b0;
      processing     <= 1'b0;
      done           <= 1'b0;
      fft_level      <= '0;
      butterfly_iter <= '0;
      load_address   <= '0;
      out_address    <= '0;
      rd_en          <= 1'b0;
      rd_bank        <= 1'b0;
      busy           <= 1'b0;
    end else begin
      state_q        <= state_d;
      cnt_q          <= cnt_d;
      level_q        <= level_d;
      iter_q         <= iter_d;
      drain_q        <= drain_d;
      sample_ready   <= in_load_d;
      load           <= in_load_d;
      processing     <= in_bfly_d;
      done           <= in_out_d;
      fft_level      <= in_bfly_d ? AW'(level_d) : '0;
      butterfly_iter <= in_proc_d ? AW'(iter_d) : '0;
      load_address   <= in_load_d ? cnt_d : '0;
      out_address    <= in_out_d ? cnt_d : '0;
      rd_en          <= in_proc_d;
      rd_bank        <= in_bfly_d ? level_d[0] : 1'b0;
      busy           <= (state_d != S_IDLE);
    end
  end

  // Write-back delay line: shifts every cycle so writes trail reads by exactly BFLY_LAT.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < int'(BFLY_LAT); i++) wb_q[i] <= '0;
    end else begin
      wb_q[0] <= '{en: rd_en, iter: butterfly_iter, level: fft_level};
      for (int i = 1; i < int'(BFLY_LAT); i++) wb_q[i] <= wb_q[i-1];
    end
  end

  assign wr_en     = wb_q[LAST_WB].en;
  assign wr_iter   = wb_q[LAST_WB].iter;
  assign wr_level  = wb_q[LAST_WB].level;
  assign load_we   = sample_valid & sample_ready;
  assign out_valid = (state_q == S_OUT);

endmodule

// File: tb/tb_fft_sequencer.sv
// Randomized bench for fft_sequencer: a frame-level reference walks load/levels/output phases
// and predicts every output per cycle, including the write-back delay.
module tb_fft_sequencer;

  localparam int LAT = 2;

  logic       clk, reset_n, start, sample_valid, out_ready;
  logic       sample_ready, load, processing, done, load_we, rd_en, wr_en, rd_bank, out_valid, busy;
  logic [5:0] fft_level, butterfly_iter, load_address, out_address, wr_iter, wr_level;

  fft_sequencer #(.BFLY_LAT(LAT)) dut (
    .clk(clk), .reset_n(reset_n), .start(start), .sample_valid(sample_valid),
    .sample_ready(sample_ready), .load(load), .processing(processing), .done(done),
    .fft_level(fft_level), .butterfly_iter(butterfly_iter), .load_address(load_address),
    .out_address(out_address), .load_we(load_we), .rd_en(rd_en), .wr_en(wr_en),
    .wr_iter(wr_iter), .wr_level(wr_level), .rd_bank(rd_bank), .out_valid(out_valid),
    .out_ready(out_ready), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic       sample_ready, load, processing, done;
    logic [5:0] fft_level, butterfly_iter, load_address, out_address;
    logic       load_we, rd_en, rd_bank, out_valid, busy;
  } exp_t;

  int total, bad;
  int n_load, n_proc, n_rd, n_wr, n_done, n_busy;
  logic [12:0] wr_hist[$];

  task automatic chk(input string tag, input int got, input int exp);
    total++;
    if (got != exp) begin
      bad++;
      if (bad <= 40) $display("FAIL %s at %0t: got %0d expected %0d", tag, $time, got, exp);
    end
  endtask

  function automatic exp_t e_idle();
    exp_t e;
    e = '0;
    return e;
  endfunction

  function automatic exp_t e_load(input int addr, input logic v);
    exp_t e;
    e = '0;
    e.sample_ready = 1'b1; e.load = 1'b1; e.load_address = 6'(addr);
    e.load_we = v; e.busy = 1'b1;
    return e;
  endfunction

  function automatic exp_t e_proc(input int lv, input int it, input bit drain);
    exp_t e;
    e = '0;
    e.processing = 1'b1; e.fft_level = 6'(lv); e.busy = 1'b1;
    e.butterfly_iter = drain ? 6'd0 : 6'(it);
    e.rd_en = !drain;
    e.rd_bank = 1'((lv % 2));
    return e;
  endfunction

  function automatic exp_t e_out(input int addr);
    exp_t e;
    e = '0;
    e.done = 1'b1; e.out_address = 6'(addr); e.out_valid = 1'b1; e.busy = 1'b1;
    return e;
  endfunction

  task automatic reset_hist();
    wr_hist.delete();
    for (int i = 0; i < LAT; i++) wr_hist.push_back(13'd0);
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_busy"}, int'(busy), 0);
    chk({tag, "_load"}, int'(load), 0);
    chk({tag, "_proc"}, int'(processing), 0);
    chk({tag, "_done"}, int'(done), 0);
    chk({tag, "_rd_en"}, int'(rd_en), 0);
    chk({tag, "_wr_en"}, int'(wr_en), 0);
    chk({tag, "_level"}, int'(fft_level), 0);
    chk({tag, "_iter"}, int'(butterfly_iter), 0);
    chk({tag, "_wr_lv_it"}, int'({wr_level, wr_iter}), 0);
    chk({tag, "_addr"}, int'({load_address, out_address}), 0);
    chk({tag, "_misc"}, int'({sample_ready, load_we, out_valid, rd_bank}), 0);
  endtask

  // Called at a falling edge after inputs are driven; checks then advances one clock.
  task automatic cycle(input exp_t e);
    logic [12:0] w;
    #1;
    wr_hist.push_back({e.rd_en, e.butterfly_iter, e.fft_level});
    w = wr_hist.pop_front();
    chk("sample_ready", int'(sample_ready), int'(e.sample_ready));
    chk("load", int'(load), int'(e.load));
    chk("processing", int'(processing), int'(e.processing));
    chk("done", int'(done), int'(e.done));
    chk("fft_level", int'(fft_level), int'(e.fft_level));
    chk("butterfly_iter", int'(butterfly_iter), int'(e.butterfly_iter));
    chk("load_address", int'(load_address), int'(e.load_address));
    chk("out_address", int'(out_address), int'(e.out_address));
    chk("load_we", int'(load_we), int'(e.load_we));
    chk("rd_en", int'(rd_en), int'(e.rd_en));
    chk("rd_bank", int'(rd_bank), int'(e.rd_bank));
    chk("out_valid", int'(out_valid), int'(e.out_valid));
    chk("busy", int'(busy), int'(e.busy));
    chk("wr_en", int'(wr_en), int'(w[12]));
    if (w[12]) begin
      chk("wr_iter", int'(wr_iter), int'(w[11:6]));
      chk("wr_level", int'(wr_level), int'(w[5:0]));
      chk("wr_bank_vs_rd_bank", int'(~wr_level[0]), int'(~e.rd_bank));
    end
    n_load += int'(load);
    n_proc += int'(processing);
    n_rd   += int'(rd_en);
    n_wr   += int'(wr_en);
    n_done += int'(done);
    n_busy += int'(busy);
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic rand_misc();
    start        = 1'($urandom_range(0, 1));
    sample_valid = 1'($urandom_range(0, 1));
    out_ready    = 1'($urandom_range(0, 1));
  endtask

  // vmode: 0 valid always, 1 toggling, 2 random. rmode: 0 ready always, 1 stall 5 at addr 10, 2 random.
  task automatic run_frame(input int vmode, input int rmode, input int idle_n, input bit abort);
    int acc, lc, oc, idx, bp;
    logic v, r;
    n_load = 0; n_proc = 0; n_rd = 0; n_wr = 0; n_done = 0; n_busy = 0;
    for (int k = 0; k < idle_n; k++) begin
      rand_misc(); start = 1'b0;
      cycle(e_idle());
    end
    rand_misc(); start = 1'b1;
    cycle(e_idle());
    acc = 0; lc = 0;
    while (acc < 64) begin
      if (vmode == 0)     v = 1'b1;
      else if (vmode == 1) v = (lc % 2 == 0);
      else                v = (lc > 400) ? 1'b1 : 1'($urandom_range(0, 1));
      rand_misc(); sample_valid = v;
      cycle(e_load(acc, v));
      if (v) acc++;
      lc++;
    end
    for (int lv = 0; lv < 6; lv++) begin
      for (int it = 0; it < 32 + LAT; it++) begin
        if (abort && lv == 3 && it == 17) begin
          chk("pre_abort_iter", int'(butterfly_iter), 17);
          #1 reset_n = 1'b0;
          #1 check_zero("async_rst");
          @(posedge clk);
          @(posedge clk);
          @(negedge clk);
          reset_n = 1'b1;
          reset_hist();
          return;
        end
        rand_misc();
        cycle(e_proc(lv, it, it >= 32));
      end
    end
    idx = 0; oc = 0; bp = 0;
    while (idx < 64) begin
      if (rmode == 0) r = 1'b1;
      else if (rmode == 1) begin
        if (idx == 10 && bp < 5) begin r = 1'b0; bp++; end
        else r = 1'b1;
      end else r = (oc > 400) ? 1'b1 : 1'($urandom_range(0, 1));
      rand_misc(); out_ready = r;
      cycle(e_out(idx));
      if (r) idx++;
      oc++;
    end
    chk("n_load", n_load, lc);
    chk("n_proc", n_proc, 6 * (32 + LAT));
    chk("n_rd", n_rd, 192);
    chk("n_wr", n_wr, 192);
    chk("n_done", n_done, oc);
    chk("n_busy", n_busy, lc + 6 * (32 + LAT) + oc);
    if (vmode == 0) chk("n_load_full", n_load, 64);
    if (vmode == 1) chk("n_load_gaps", n_load, 127);
    if (vmode == 0 && rmode == 0) chk("n_busy_full", n_busy, 332);
    if (rmode == 1) chk("n_done_stall", n_done, 69);
  endtask

  initial begin
    total = 0; bad = 0;
    reset_n = 1'b0; start = 1'b0; sample_valid = 1'b0; out_ready = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_zero("rst_hold");
    reset_n = 1'b1;
    reset_hist();
    cycle(e_idle());
    cycle(e_idle());
    run_frame(0, 0, 1, 1'b0);
    run_frame(1, 1, 0, 1'b0);
    run_frame(2, 2, 2, 1'b1);
    run_frame(0, 1, 0, 1'b0);
    run_frame(2, 2, 0, 1'b0);
    run_frame(2, 0, 3, 1'b0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/fft_sequencer.md
Name: fft_sequencer

Overview:
- Control FSM for the 64-point in-place radix-2 FFT core.
- Sits directly upstream of the FFT address-generation unit. Drives its load/processing/done mode flags, fft_level, butterfly_iter, load_address and out_address.
- Also drives RAM write enables, ping-pong bank select, and a delayed write-back index that matches the butterfly pipeline latency.
- Sequences one frame as: accept 64 samples → 6 levels × 32 butterflies → stream 64 results out.

Parameters:
- BFLY_LAT, 2, cycles from butterfly read issue to write-back (legal 1..7); sets wr_* delay and the per-level drain length.

Ports:
- clk  in  1  system clock, rising edge
- reset_n  in  1  asynchronous active-low reset
- start  in  1  begin a frame; sampled only in IDLE
- sample_valid  in  1  input sample present this cycle
- sample_ready  out  1  sequencer accepts a sample this cycle
- load  out  1  high in LOAD state
- processing  out  1  high in PROC and DRAIN states
- done  out  1  high in OUT state
- fft_level  out  6  current level, 0..5
- butterfly_iter  out  6  read butterfly index, 0..31
- load_address  out  6  natural-order index of the sample being written
- out_address  out  6  natural-order index of the result being read out
- load_we  out  1  sample_valid & sample_ready (combinational)
- rd_en  out  1  butterfly read issued this cycle
- wr_en  out  1  butterfly write-back this cycle
- wr_iter  out  6  butterfly_iter delayed BFLY_LAT cycles
- wr_level  out  6  fft_level delayed BFLY_LAT cycles
- rd_bank  out  1  bank being read; writes go to the opposite bank
- out_valid  out  1  result at out_address available
- out_ready  in  1  downstream accepts a result
- busy  out  1  state != IDLE

Behaviour:
- Clock and reset: single clock domain. Reset is asynchronous and active-low. reset_n=0 forces IDLE and clears all counters and the delay pipeline immediately, including mid-frame. Every output reads 0 during and immediately after reset.
- State machine: IDLE → LOAD → PROC ⇄ DRAIN → OUT → IDLE.
- IDLE:
  - All outputs 0.
  - start=1 → LOAD on the next edge, with cnt=0.
  - start in any other state is ignored.
- LOAD:
  - load=1, sample_ready=1, load_address=cnt.
  - On each cycle with sample_valid=1: the sample is accepted and cnt increments.
  - Gaps in sample_valid stall cnt with no other effect.
  - Acceptance at cnt=63 → PROC, with level=0 and iter=0.
  - rd_bank=0; loads write bank 0.
- PROC:
  - processing=1, rd_en=1, butterfly_iter=iter, fft_level=level, rd_bank=level[0].
  - iter increments each cycle. At iter=31 → DRAIN.
- DRAIN:
  - processing=1, rd_en=0, lasts exactly BFLY_LAT cycles. This guarantees the level's last write lands before the next level reads.
  - On exit: if level<5, level+1 and → PROC with iter=0; if level=5, → OUT with cnt=0.
- Per-level timing: 32+BFLY_LAT cycles, so the whole transform takes 6*(32+BFLY_LAT) cycles.
- Write-back pipeline:
  - wr_en, wr_iter and wr_level are rd_en, butterfly_iter and fft_level delayed exactly BFLY_LAT cycles through a register chain.
  - The chain shifts in every cycle regardless of state.
  - wr_en=0 whenever the delayed rd_en=0.
- Bank usage:
  - Writes target bank ~wr_level[0].
  - Level 5 writes bank 0, so results are in bank 0.
- OUT:
  - done=1, out_valid=1, out_address=cnt, rd_bank=0.
  - out_valid & out_ready advances cnt. out_ready=0 holds cnt and out_address stable.
  - Handshake at cnt=63 → IDLE; busy drops on that edge.
- Output rules:
  - Outputs not used in a state are driven 0. In particular, butterfly_iter and fft_level are 0 outside PROC/DRAIN, and fft_level holds its value during DRAIN.
  - All outputs are registered, except load_we and out_valid, which are decoded combinationally from registered state.
- Counters never exceed 63; no wrap occurs in normal operation.

Test Plan:
- Reset: hold reset_n=0 for 3 cycles, then release → all outputs 0, busy=0. Assert reset_n=0 asynchronously mid-PROC at level=3, iter=17 → outputs 0 within the same cycle; the next start restarts from load_address=0.
- Full frame, BFLY_LAT=2, sample_valid=1 continuously, out_ready=1:
  - load high exactly 64 cycles, load_address 0..63.
  - processing high 204 cycles; rd_en high 192 cycles.
  - fft_level steps 0..5, each held 34 cycles.
  - done high 64 cycles; busy high 332 cycles.
- Load gaps: sample_valid toggles 1,0,1,0,... → load_address advances only on valid cycles. LOAD lasts 127 cycles and exits after the 64th acceptance.
- Write-back alignment: check that wr_iter(t)==butterfly_iter(t-2) and wr_level(t)==fft_level(t-2) whenever wr_en=1. Check wr_en count=192 per frame, and rd_bank==~write bank on every write.
- Output backpressure: in OUT, drive out_ready low for 5 cycles at out_address=10 → out_address holds 10, out_valid stays 1, and addresses 11..63 follow after release.
- Start while busy: pulse start during LOAD, PROC and OUT → no state change, no counter reset. A start issued 1 cycle after return to IDLE begins a new LOAD.
